// File: rtl/rs_dec_arb.sv
`default_nettype none
// ============================================================================
// Module   : rs_dec_arb
// Brief    : Shares one rs_decoder between two 64-bit channels, one whole
//            4-codeword alignment group per grant, with in-order result routing.
// Revision : 1.0 - initial release
// ============================================================================
module rs_dec_arb #(
  parameter int GRP_BEATS = 99,
  parameter int OUT_BEATS = 96,
  parameter int TAG_DEPTH = 4,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_ena,
  input  logic              ch0_vld,
  input  logic [63:0]       ch0_data,
  output logic              ch0_rdy,
  input  logic              ch1_vld,
  input  logic [63:0]       ch1_data,
  output logic              ch1_rdy,
  output logic              rs_ena,
  output logic              rx_vld,
  output logic [63:0]       rx_data,
  input  logic              dec_vld,
  input  logic [63:0]       dec_data,
  input  logic              dec_isos,
  input  logic              rde_error,
  output logic              out0_vld,
  output logic              out1_vld,
  output logic [63:0]       out_data,
  output logic              out_isos,
  output logic [ERR_W-1:0]  err_cnt0,
  output logic [ERR_W-1:0]  err_cnt1,
  output logic              proto_err,
  output logic              busy
);

  localparam int c_in_w  = $clog2(GRP_BEATS);
  localparam int c_out_w = $clog2(OUT_BEATS);
  localparam int c_ptr_w = $clog2(TAG_DEPTH);
  localparam logic [c_in_w-1:0]  c_grp_last = c_in_w'(GRP_BEATS - 1);
  localparam logic [c_out_w-1:0] c_out_last = c_out_w'(OUT_BEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [c_in_w-1:0]    in_cnt_q, in_cnt_d;
  logic [c_out_w-1:0]   out_cnt_q;
  logic [TAG_DEPTH-1:0] tag_q;
  logic [c_ptr_w:0]     wr_ptr_q, rd_ptr_q;
  logic [ERR_W-1:0]     err0_q, err1_q;
  logic                 proto_q;
  logic                 rs_ena_q;

  logic w_push, w_pop, w_beat, w_empty, w_full, w_head, w_dec_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                   (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
  assign w_head  = tag_q[rd_ptr_q[c_ptr_w-1:0]];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    in_cnt_d = in_cnt_q;
    w_push   = 1'b0;
    w_beat   = 1'b0;
    ch0_rdy  = 1'b0;
    ch1_rdy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_ena && !w_full && (ch0_vld || ch1_vld)) begin
          owner_d  = (ch0_vld && ch1_vld) ? ~last_q : ch1_vld;
          last_d   = owner_d;
          in_cnt_d = '0;
          w_push   = 1'b1;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        ch0_rdy = ~owner_q;
        ch1_rdy = owner_q;
        w_beat  = owner_q ? ch1_vld : ch0_vld;
        if (w_beat) begin
          if (in_cnt_q == c_grp_last) begin
            in_cnt_d = '0;
            state_d  = S_IDLE;
          end else begin
            in_cnt_d = in_cnt_q + c_in_w'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      in_cnt_q <= '0;
      rs_ena_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      in_cnt_q <= in_cnt_d;
      rs_ena_q <= cfg_ena;
    end
  end

  assign rx_vld  = w_beat;
  assign rx_data = w_beat ? (owner_q ? ch1_data : ch0_data) : '0;
  assign rs_ena  = rs_ena_q;

  // Decoder results without an owning group are dropped and flagged instead.
  assign w_dec_ok = dec_vld && !w_empty;
  assign w_pop    = w_dec_ok && (out_cnt_q == c_out_last);
  assign out0_vld = w_dec_ok && !w_head;
  assign out1_vld = w_dec_ok && w_head;
  assign out_data = dec_data;
  assign out_isos = dec_isos;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_cnt_q <= '0;
      err0_q    <= '0;
      err1_q    <= '0;
      proto_q   <= 1'b0;
    end else begin
      if (w_push) begin
        tag_q[wr_ptr_q[c_ptr_w-1:0]] <= owner_d;
        wr_ptr_q <= wr_ptr_q + (c_ptr_w+1)'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + (c_ptr_w+1)'(1);
      end
      if (w_dec_ok) begin
        out_cnt_q <= w_pop ? '0 : out_cnt_q + c_out_w'(1);
      end
      if (rde_error && !w_empty) begin
        if (!w_head && (err0_q != '1)) err0_q <= err0_q + ERR_W'(1);
        if (w_head && (err1_q != '1))  err1_q <= err1_q + ERR_W'(1);
      end
      if ((dec_vld || rde_error) && w_empty) begin
        proto_q <= 1'b1;
      end
    end
  end

  assign err_cnt0  = err0_q;
  assign err_cnt1  = err1_q;
  assign proto_err = proto_q;
  assign busy      = (state_q == S_XFER) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_rs_dec_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_dec_arb
// Brief    : Directed scoreboard bench for rs_dec_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_dec_arb;
  localparam int GRP  = 99;
  localparam int OUTB = 96;

  logic        clk = 1'b0;
  logic        rstn, cfg_ena;
  logic        ch0_vld, ch1_vld, ch0_rdy, ch1_rdy;
  logic [63:0] ch0_data, ch1_data;
  logic        rs_ena, rx_vld;
  logic [63:0] rx_data;
  logic        dec_vld, dec_isos, rde_error;
  logic [63:0] dec_data;
  logic        out0_vld, out1_vld, out_isos;
  logic [63:0] out_data;
  logic [15:0] err_cnt0, err_cnt1;
  logic        proto_err, busy;

  rs_dec_arb #(.GRP_BEATS(99), .OUT_BEATS(96), .TAG_DEPTH(4), .ERR_W(16)) dut (
    .clk(clk), .rstn(rstn), .cfg_ena(cfg_ena),
    .ch0_vld(ch0_vld), .ch0_data(ch0_data), .ch0_rdy(ch0_rdy),
    .ch1_vld(ch1_vld), .ch1_data(ch1_data), .ch1_rdy(ch1_rdy),
    .rs_ena(rs_ena), .rx_vld(rx_vld), .rx_data(rx_data),
    .dec_vld(dec_vld), .dec_data(dec_data), .dec_isos(dec_isos), .rde_error(rde_error),
    .out0_vld(out0_vld), .out1_vld(out1_vld), .out_data(out_data), .out_isos(out_isos),
    .err_cnt0(err_cnt0), .err_cnt1(err_cnt1), .proto_err(proto_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ch;
    logic        isos;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  bit   obs_ch[$];
  int   obs_cyc[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   left[2], seq[2], pause_at[2], pause_len[2], pcnt[2];
  int   grp_beats, rx_total, rxv_cnt, viol, last_out_cyc;
  int   rdy_cnt[2];
  bit   cur_own;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mkdata(input int c, input int s);
    return {(c != 0) ? 32'hC1C1_0001 : 32'hC0C0_0000, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Channel sources: each accepted beat advances that channel's sequence number.
  initial begin
    bit fire[2];
    bit v[2];
    ch0_vld = 1'b0; ch1_vld = 1'b0; ch0_data = '0; ch1_data = '0;
    forever begin
      @(negedge clk);
      fire[0] = ch0_vld && ch0_rdy;
      fire[1] = ch1_vld && ch1_rdy;
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (fire[c]) begin left[c]--; seq[c]++; end
        v[c] = (left[c] > 0);
        if (v[c] && seq[c] == pause_at[c] && pcnt[c] < pause_len[c]) begin
          v[c] = 1'b0;
          pcnt[c]++;
        end
      end
      ch0_vld = v[0]; ch0_data = mkdata(0, seq[0]);
      ch1_vld = v[1]; ch1_data = mkdata(1, seq[1]);
    end
  end

  // Input-side monitor: records grants and flags protocol breaches.
  always @(negedge clk) begin
    if (rstn) begin
      bit f0, f1, c;
      f0 = ch0_vld && ch0_rdy;
      f1 = ch1_vld && ch1_rdy;
      if (ch0_rdy) rdy_cnt[0]++;
      if (ch1_rdy) rdy_cnt[1]++;
      if (rx_vld) rxv_cnt++;
      if (ch0_rdy && ch1_rdy) viol++;
      if (rx_vld !== (f0 || f1)) viol++;
      if (f0 || f1) begin
        c = f1;
        if (rx_data !== mkdata(int'(c), seq[c])) viol++;
        if (grp_beats == 0) begin
          obs_ch.push_back(c);
          obs_cyc.push_back(cyc);
          cur_own = c;
        end else if (c != cur_own) begin
          viol++;
        end
        grp_beats = (grp_beats == GRP - 1) ? 0 : grp_beats + 1;
        rx_total++;
      end
      if (grp_beats != 0 && ((cur_own == 1'b0 && ch1_rdy) || (cur_own == 1'b1 && ch0_rdy))) viol++;
    end
  end

  // Output-side monitor: pops the scoreboard on every routed decoder beat.
  always @(negedge clk) begin
    if (rstn && (out0_vld || out1_vld)) begin
      exp_t e;
      checks++;
      last_out_cyc = cyc;
      if (out0_vld && out1_vld) begin
        errors++;
        $display("FAIL out_both: out0_vld=%0b out1_vld=%0b required one-hot", out0_vld, out1_vld);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: out0=%0b out1=%0b data=%0h required no output", out0_vld, out1_vld, out_data);
      end else begin
        e = sb_q.pop_front();
        if (out1_vld !== e.ch || out_data !== e.data || out_isos !== e.isos) begin
          errors++;
          $display("FAIL out_beat: ch=%0b data=%0h isos=%0b required ch=%0b data=%0h isos=%0b",
                   out1_vld, out_data, out_isos, e.ch, e.data, e.isos);
        end
      end
    end
  end

  task automatic dec_group(input logic ch, input int nerr);
    exp_t e;
    for (int i = 0; i < OUTB; i++) begin
      @(posedge clk);
      #1;
      dec_vld   = 1'b1;
      dec_data  = {16'hDEC0, 15'd0, ch, 32'(i * 3 + 7)};
      dec_isos  = (i % 24 == 0);
      rde_error = (i % 24 == 23) && (i / 24 < nerr);
      e.ch = ch; e.isos = dec_isos; e.data = dec_data;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    dec_vld = 1'b0; rde_error = 1'b0; dec_isos = 1'b0; dec_data = '0;
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int k = 0;
    while (rx_total < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (rx_total < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: beats %0d required %0d", name, rx_total, target);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0; cfg_ena = 1'b0; left[0] = 0; left[1] = 0;
    dec_vld = 1'b0; rde_error = 1'b0; dec_data = '0; dec_isos = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int c = 0; c < 2; c++) begin
      seq[c] = 0; pcnt[c] = 0; pause_at[c] = -1; pause_len[c] = 0; rdy_cnt[c] = 0;
    end
    obs_ch.delete(); obs_cyc.delete(); sb_q.delete();
    grp_beats = 0; rx_total = 0; rxv_cnt = 0; viol = 0; cur_own = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_rs_ena", rs_ena, 0);
    chk("rst_rdy_rx", {ch0_rdy, ch1_rdy, rx_vld}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err_cnt0, err_cnt1}, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_outvld", {out0_vld, out1_vld}, 0);

    // Channel 0 alone, one group
    @(posedge clk); #2; cfg_ena = 1'b1;
    @(negedge clk); chk("rs_ena_lag", rs_ena, 0);
    @(negedge clk); chk("rs_ena_on", rs_ena, 1);
    @(posedge clk); #2; left[0] = GRP;
    wait_beats(99, 400, "t1_xfer");
    repeat (20) @(posedge clk);
    #2;
    chk("t1_rx_vld_cycles", rxv_cnt, 99);
    chk("t1_groups", obs_ch.size(), 1);
    chk("t1_owner", obs_ch[0], 0);
    chk("t1_ch1_rdy_cycles", rdy_cnt[1], 0);
    chk("t1_busy_pending", busy, 1);
    dec_group(1'b0, 0);
    @(negedge clk);
    chk("t1_busy_done", busy, 0);
    chk("t1_err0", err_cnt0, 0);
    chk("t1_sb_empty", sb_q.size(), 0);
    chk("t1_rx_protocol", viol, 0);

    // Both channels continuously requesting
    do_reset();
    cfg_ena = 1'b1; left[0] = 2 * GRP; left[1] = 2 * GRP;
    wait_beats(4 * GRP, 1000, "t2_xfer");
    chk("t2_groups", obs_ch.size(), 4);
    if (obs_ch.size() >= 4) begin
      chk("t2_order", {obs_ch[0], obs_ch[1], obs_ch[2], obs_ch[3]}, 4'b0101);
      for (int i = 1; i < 4; i++) chk("t2_gap", obs_cyc[i] - obs_cyc[i-1], 100);
    end
    dec_group(1'b0, 0); dec_group(1'b1, 0); dec_group(1'b0, 0); dec_group(1'b1, 0);
    @(negedge clk);
    chk("t2_sb_empty", sb_q.size(), 0);
    chk("t2_busy_done", busy, 0);
    chk("t2_rx_protocol", viol, 0);

    // Owner pauses mid-group while the other channel waits
    do_reset();
    cfg_ena = 1'b1; pause_at[0] = 50; pause_len[0] = 10; left[0] = GRP; left[1] = GRP;
    wait_beats(2 * GRP, 600, "t3_xfer");
    chk("t3_groups", obs_ch.size(), 2);
    if (obs_ch.size() >= 2) begin
      chk("t3_order", {obs_ch[0], obs_ch[1]}, 2'b01);
      chk("t3_gap", obs_cyc[1] - obs_cyc[0], 110);
    end
    chk("t3_rx_protocol", viol, 0);
    dec_group(1'b0, 0); dec_group(1'b1, 0);
    @(negedge clk);
    chk("t3_sb_empty", sb_q.size(), 0);

    // Decoder stalled: tag FIFO fills, then one pop frees a slot
    do_reset();
    cfg_ena = 1'b1; left[0] = 3 * GRP; left[1] = 3 * GRP;
    wait_beats(4 * GRP, 1000, "t4_fill");
    repeat (150) @(posedge clk);
    #2;
    chk("t4_no_fifth", obs_ch.size(), 4);
    chk("t4_rx_total", rx_total, 4 * GRP);
    chk("t4_busy", busy, 1);
    dec_group(1'b0, 0);
    wait_beats(4 * GRP + 1, 20, "t4_regrant");
    chk("t4_groups_after", obs_ch.size(), 5);
    if (obs_ch.size() >= 5) begin
      chk("t4_regrant_lat", obs_cyc[4] - last_out_cyc, 2);
      chk("t4_fifth_owner", obs_ch[4], 0);
    end
    chk("t4_rx_protocol", viol, 0);

    // Fail attribution and saturation
    do_reset();
    cfg_ena = 1'b1; left[0] = 2 * GRP; left[1] = GRP;
    wait_beats(3 * GRP, 1000, "t5_xfer");
    chk("t5_groups", obs_ch.size(), 3);
    if (obs_ch.size() >= 3) chk("t5_order", {obs_ch[0], obs_ch[1], obs_ch[2]}, 3'b010);
    dec_group(1'b0, 1);
    @(negedge clk);
    chk("t5_err0_one", err_cnt0, 1);
    chk("t5_err1_zero", err_cnt1, 0);
    dec_group(1'b1, 2);
    @(negedge clk);
    chk("t5_err1_two", err_cnt1, 2);
    chk("t5_err0_still", err_cnt0, 1);
    dut.err0_q = 16'hFFFE;
    dec_group(1'b0, 3);
    @(negedge clk);
    chk("t5_err0_sat", err_cnt0, 16'hFFFF);
    chk("t5_err1_hold", err_cnt1, 2);
    chk("t5_sb_empty", sb_q.size(), 0);

    // Enable dropped mid-group, then decoder output with nothing owed
    do_reset();
    cfg_ena = 1'b1; left[0] = 2 * GRP;
    wait_beats(30, 200, "t6_beat30");
    cfg_ena = 1'b0;
    wait_beats(GRP, 200, "t6_finish");
    repeat (150) @(posedge clk);
    #2;
    chk("t6_rx_total", rx_total, GRP);
    chk("t6_groups", obs_ch.size(), 1);
    chk("t6_rs_ena_off", rs_ena, 0);
    dec_group(1'b0, 0);
    @(negedge clk);
    chk("t6_busy_done", busy, 0);
    chk("t6_proto_before", proto_err, 0);
    @(posedge clk); #1; dec_vld = 1'b1; dec_data = 64'h5A5A_0000_0000_0001;
    @(posedge clk); #1; dec_vld = 1'b0; rde_error = 1'b1;
    @(posedge clk); #1; rde_error = 1'b0;
    @(negedge clk);
    chk("t6_proto_set", proto_err, 1);
    chk("t6_no_err_count", err_cnt0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_proto_sticky", proto_err, 1);
    chk("t6_rx_protocol", viol, 0);
    do_reset();
    @(negedge clk);
    chk("t6_proto_reset", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_dec_arb.md
Name: rs_dec_arb

Overview:
- Time-shares one rs_decoder between two 64-bit input channels.
- Grants the decoder one whole alignment group at a time (4 codewords = 99 input beats), so the decoder's codeword phase counters never see a channel switch mid-group.
- Tracks group ownership in a tag FIFO so decoded output (dec_vld/dec_data/dec_isos) and decode-failure events are routed back to the owning channel in order.
- Sits between the link-side channel buffers and rs_decoder.

Parameters:
- GRP_BEATS, 99: input beats per grant (3×25 + 24 words, one 4-codeword alignment group).
- OUT_BEATS, 96: decoder output beats per group (4×24).
- TAG_DEPTH, 4: ownership FIFO depth, in groups (power of 2).
- ERR_W, 16: width of per-channel saturating fail counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active-low
- cfg_ena  in  1  enable; low blocks new grants
- ch0_vld  in  1  channel 0 beat valid
- ch0_data  in  64  channel 0 beat data
- ch0_rdy  out  1  channel 0 beat accepted when vld&rdy
- ch1_vld  in  1  channel 1 beat valid
- ch1_data  in  64  channel 1 beat data
- ch1_rdy  out  1  channel 1 beat accepted when vld&rdy
- rs_ena  out  1  to decoder rs_ena (registered cfg_ena)
- rx_vld  out  1  to decoder rx_vld
- rx_data  out  64  to decoder rx_data
- dec_vld  in  1  from decoder
- dec_data  in  64  from decoder
- dec_isos  in  1  from decoder
- rde_error  in  1  from decoder, one-cycle fail pulse per failed codeword
- out0_vld  out  1  decoded beat for channel 0
- out1_vld  out  1  decoded beat for channel 1
- out_data  out  64  decoded data (shared by both channels)
- out_isos  out  1  decoded isos flag (shared)
- err_cnt0  out  ERR_W  channel 0 fail count
- err_cnt1  out  ERR_W  channel 1 fail count
- proto_err  out  1  sticky: dec_vld or rde_error with empty tag FIFO
- busy  out  1  state is XFER or tag FIFO non-empty

Behaviour:
- Reset values:
  - state IDLE, last-served pointer = 1 (so channel 0 wins the first tie).
  - All outputs 0; beat counters 0; tag FIFO empty; rs_ena 0.
- rs_ena: cfg_ena registered by one flop.
- FSM:
  - IDLE -> XFER: when cfg_ena && !tag_full && (ch0_vld || ch1_vld).
  - Owner selection: the sole requester; if both request, the channel other than last-served (round-robin).
  - On that transition: push owner id into the tag FIFO, set last-served = owner, clear in_cnt.
  - XFER: chX_rdy = 1 for the owner only; the other rdy = 0. All rdy = 0 in IDLE.
  - A beat is chX_vld && chX_rdy. Per beat: rx_vld = 1 and rx_data = owner data (combinational, same cycle); in_cnt increments.
  - Owner may drop vld mid-group: rx_vld stays 0, no switch or timeout, the grant is held.
  - XFER -> IDLE: on the beat where in_cnt == GRP_BEATS-1. The earliest next grant is the following cycle, giving one idle cycle between groups.
  - cfg_ena falling during XFER: current group completes; no further grants.
- Output side:
  - out_data = dec_data, out_isos = dec_isos (pass-through).
  - out0_vld = dec_vld && head==0 && !empty; out1_vld likewise for head==1.
  - out_cnt counts dec_vld beats. On beat OUT_BEATS-1: pop tag, clear out_cnt.
- Fail attribution:
  - rde_error increments err_cnt[head] (saturating at all-ones) when the tag FIFO is non-empty.
  - dec_vld or rde_error with an empty FIFO sets proto_err; no count, no outvld.
- Tag FIFO full/empty:
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - Full blocks new grants only, never an in-progress XFER.
- Reset mid-group clears everything. The decoder is on the same rstn, so alignment stays consistent.

Test Plan:
- Channel 0 only, 99 beats of an incrementing pattern with valid codewords.
  -> rx_vld high for exactly 99 cycles, ch1_rdy = 0 throughout; 96 out0_vld beats with correct data; err_cnt0 = 0; busy drops after the last output beat.
- Both channels requesting continuously.
  -> Grants alternate ch0, ch1, ch0, ch1, with one idle cycle between groups; output beats routed to the matching outX_vld in grant order.
- Channel 0 deasserts vld for 10 cycles at beat 50 while channel 1 is requesting.
  -> Grant held; ch1_rdy stays 0; the group completes at beat 99; ch1 is granted next.
- Decoder stalled (no dec_vld) while both channels request.
  -> After 4 grants the tag FIFO is full and no 5th grant occurs. After the first 96 output beats a pop occurs and a new grant starts within 2 cycles.
- Inject 2 uncorrectable codewords in a channel-1 group and 1 in a channel-0 group.
  -> err_cnt1 = 2, err_cnt0 = 1. With err_cnt forced near max, saturates at 0xFFFF.
- Drop cfg_ena at beat 30 of a group; separately pulse dec_vld with an empty FIFO.
  -> The group finishes all 99 beats and no new grant follows; proto_err = 1 and stays set until reset.
